// File: rtl/led_msg_sequencer.sv
// Streams a byte message from a synchronous-read ROM onto the badge LEDs, one
// byte per display period, with a req/ack override that can take the LEDs at any time.
`timescale 1ns/1ps
module led_msg_sequencer #(
  parameter int unsigned TICK_DIV = 160000,
  parameter int unsigned MSG_LEN  = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LOOP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              ovr_req,
  input  logic [7:0]        ovr_data,
  output logic              ovr_ack,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHOW, DONE} state_t;

  localparam logic [31:0]       TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(MSG_LEN - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [31:0]       tick, tick_next;
  logic [7:0]        byte_reg, byte_next;
  logic [7:0]        led_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tick     <= '0;
      byte_reg <= '0;
      led      <= '0;
      ovr_ack  <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      tick     <= tick_next;
      byte_reg <= byte_next;
      led      <= led_next;
      ovr_ack  <= ovr_req;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    tick_next  = tick;
    byte_next  = byte_reg;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        byte_next  = mem_data;
        tick_next  = '0;
        state_next = SHOW;
      end
      SHOW: begin
        // The display period is paused for as long as the override holds the LEDs.
        if (!ovr_ack) begin
          if (tick == TICK_LAST) begin
            tick_next = '0;
            if (idx < IDX_LAST) begin
              idx_next   = idx + ADDR_W'(1);
              state_next = FETCH;
            end else if (LOOP != 0) begin
              idx_next   = '0;
              state_next = FETCH;
            end else begin
              state_next = DONE;
            end
          end else begin
            tick_next = tick + 32'd1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (stop) begin
      state_next = IDLE;
      idx_next   = '0;
      tick_next  = '0;
      byte_next  = byte_reg;
    end
  end

  // byte_next (not byte_reg) so a freshly loaded byte reaches the pins one cycle after LOAD.
  assign led_next = ovr_ack ? ovr_data : byte_next;
  assign mem_rd   = (state == FETCH);
  assign mem_addr = idx;
  assign busy     = (state == FETCH) || (state == LOAD) || (state == SHOW);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_led_msg_sequencer.sv
// Bench for led_msg_sequencer: a LOOP=0 and a LOOP=1 instance share stimulus and are
// compared each cycle against a display-period model built from the message rules.
`timescale 1ns/1ps
module tb_led_msg_sequencer;
  localparam int TD = 4;
  localparam int ML = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          ovr_req = 1'b0;
  logic [7:0]    ovr_data = 8'h00;
  logic          rd [2];
  logic [AW-1:0] addr [2];
  logic [7:0]    mdata [2];
  logic          ack [2];
  logic [7:0]    led [2];
  logic          busy [2];
  logic          done [2];
  logic [15:0]   obs [2];

  logic [7:0] rom [ML] = '{8'd103, 8'd114, 8'd121, 8'd123};

  led_msg_sequencer #(.TICK_DIV(TD), .MSG_LEN(ML), .ADDR_W(AW), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mem_rd(rd[0]), .mem_addr(addr[0]),
    .mem_data(mdata[0]), .ovr_req(ovr_req), .ovr_data(ovr_data), .ovr_ack(ack[0]),
    .led(led[0]), .busy(busy[0]), .done(done[0]));

  led_msg_sequencer #(.TICK_DIV(TD), .MSG_LEN(ML), .ADDR_W(AW), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mem_rd(rd[1]), .mem_addr(addr[1]),
    .mem_data(mdata[1]), .ovr_req(ovr_req), .ovr_data(ovr_data), .ovr_ack(ack[1]),
    .led(led[1]), .busy(busy[1]), .done(done[1]));

  always @(posedge clk) if (rd[0]) mdata[0] <= rom[addr[0]];
  always @(posedge clk) if (rd[1]) mdata[1] <= rom[addr[1]];

  for (genvar gi = 0; gi < 2; gi++) begin : g_obs
    assign obs[gi] = {led[gi], busy[gi], rd[gi], done[gi], ack[gi], rd[gi] ? addr[gi] : 4'h0};
  end

  // Model: each byte occupies a period of TD+2 positions (0 fetch, 1 load, 2.. show).
  bit       m_act [2];
  bit       m_done [2];
  bit       m_ack [2];
  int       m_pos [2];
  int       m_idx [2];
  logic [7:0] m_byte [2];
  logic [7:0] m_led [2];
  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_done[k] = 0; m_ack[k] = 0;
      m_pos[k] = 0; m_idx[k] = 0; m_byte[k] = 8'h00; m_led[k] = 8'h00;
    end
  endtask

  task automatic model_edge(input logic s, input logic st, input logic rq, input logic [7:0] od);
    for (int k = 0; k < 2; k++) begin
      bit         old_ack;
      logic [7:0] nb;
      nb = (m_act[k] && m_pos[k] == 1 && !st) ? rom[m_idx[k]] : m_byte[k];
      m_led[k]  = m_ack[k] ? od : nb;
      m_byte[k] = nb;
      old_ack   = m_ack[k];
      m_ack[k]  = rq;
      if (st) begin
        m_act[k] = 0; m_done[k] = 0; m_idx[k] = 0; m_pos[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (!m_act[k]) begin
        if (s) begin m_act[k] = 1; m_pos[k] = 0; m_idx[k] = 0; end
      end else if (m_pos[k] >= 2 && old_ack) begin
        m_pos[k] = m_pos[k];
      end else if (m_pos[k] == TD + 1) begin
        m_pos[k] = 0;
        if (m_idx[k] < ML - 1) m_idx[k] = m_idx[k] + 1;
        else if (k == 1) m_idx[k] = 0;
        else begin m_act[k] = 0; m_done[k] = 1; end
      end else begin
        m_pos[k] = m_pos[k] + 1;
      end
    end
  endtask

  function automatic logic [15:0] expv(input int k);
    logic r;
    r = m_act[k] && m_pos[k] == 0;
    return {m_led[k], logic'(m_act[k]), r, logic'(m_done[k]), logic'(m_ack[k]), r ? 4'(m_idx[k]) : 4'h0};
  endfunction

  task automatic step();
    logic s, st, rq;
    logic [7:0] od;
    s = start; st = stop; rq = ovr_req; od = ovr_data;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(s, st, rq, od);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; ovr_req = 0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== 16'h0000) $display("FAIL reset_idle dut%0d c%0d got %h want 0000", k, c, obs[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sequence();
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== expv(k)) $display("FAIL seq dut%0d c%0d got %h want %h", k, c, obs[k], expv(k));
        else n_pass++;
      end
      if (c == 3 || c == 9 || c == 15 || c == 21) begin
        n_checks++;
        if (led[0] !== rom[(c - 3) / 6]) $display("FAIL seq_led c%0d got %0d want %0d", c, led[0], rom[(c - 3) / 6]);
        else n_pass++;
      end
      if (c >= 20) begin
        n_checks++;
        if (done[0] !== (c == 25)) $display("FAIL seq_done c%0d got %b want %b", c, done[0], c == 25);
        else n_pass++;
      end
      if (c == 27) begin
        n_checks++;
        if (led[1] !== 8'd103 || done[1] !== 1'b0) $display("FAIL loop_wrap got led %0d done %b want 103 0", led[1], done[1]);
        else n_pass++;
      end
    end
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  task automatic test_override();
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      start = 1'b0;
      ovr_req  = (c >= 10 && c < 20);
      ovr_data = 8'hAA;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== expv(k)) $display("FAIL ovr dut%0d c%0d got %h want %h", k, c, obs[k], expv(k));
        else n_pass++;
      end
      if (c == 12 || c == 21 || c == 22) begin
        n_checks++;
        if (led[0] !== ((c == 22) ? 8'd114 : 8'hAA)) $display("FAIL ovr_led c%0d got %h want %h", c, led[0], (c == 22) ? 8'd114 : 8'hAA);
        else n_pass++;
      end
      if (c == 23) begin
        n_checks++;
        if (rd[0] !== 1'b1 || addr[0] !== 4'd2) $display("FAIL ovr_extend got rd %b addr %0d want 1 2", rd[0], addr[0]);
        else n_pass++;
      end
    end
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  task automatic test_stop();
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      start = (c == 19);
      stop  = (c == 16);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== expv(k)) $display("FAIL stop dut%0d c%0d got %h want %h", k, c, obs[k], expv(k));
        else n_pass++;
      end
      if (c == 17) begin
        n_checks++;
        if (busy[0] !== 1'b0 || led[0] !== 8'd121 || done[0] !== 1'b0)
          $display("FAIL stop_idle got busy %b led %0d done %b want 0 121 0", busy[0], led[0], done[0]);
        else n_pass++;
      end
      if (c == 23) begin
        n_checks++;
        if (led[0] !== 8'd103) $display("FAIL stop_replay got %0d want 103", led[0]);
        else n_pass++;
      end
    end
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs[k] !== 16'h0000) $display("FAIL async_reset dut%0d got %h want 0000", k, obs[k]);
      else n_pass++;
    end
    model_reset();
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== expv(k)) $display("FAIL start_held dut%0d c%0d got %h want %h", k, c, obs[k], expv(k));
        else n_pass++;
      end
    end
    start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(80) == 0);
      if ($urandom_range(15) == 0) ovr_req = ~ovr_req;
      ovr_data = 8'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs[k] !== expv(k)) $display("FAIL rand dut%0d c%0d got %h want %h", k, c, obs[k], expv(k));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_override();
    test_stop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
